// File: rtl/arm_mem_responder.sv
// Memory-side responder for the single-cycle ArmCpu: instruction/data memories,
// one memory-mapped output register and a byte-stream program loader.
module arm_mem_responder #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [31:0] IO_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        cpu_reset,
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_byte,
  input  logic        ld_done,
  output logic        ld_overflow,
  output logic [31:0] io_out
);

  localparam int unsigned IA = $clog2(IMEM_WORDS);
  localparam int unsigned DA = $clog2(DMEM_WORDS);
  localparam int unsigned PW = IA + 1;
  localparam logic [PW-1:0] PTR_FULL   = PW'(IMEM_WORDS);
  localparam logic [31:0]   IMEM_BYTES = 32'(4 * IMEM_WORDS);
  localparam logic [31:0]   DMEM_BYTES = 32'(4 * DMEM_WORDS);

  typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;

  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [31:0]   asm_q, asm_nx, asm_ins, word;
  logic          ovf_nx, commit, im_we;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic dm_we, io_we;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    asm_nx   = asm_q;
    ovf_nx   = ld_overflow;
    commit   = 1'b0;
    im_we    = 1'b0;
    asm_ins  = asm_q;
    asm_ins[{cnt, 3'b000} +: 8] = ld_byte;
    word     = ld_valid ? asm_ins : asm_q;

    case (state)
      HOLD: state_nx = ld_start ? LOAD : RUN;
      RUN:  if (ld_start) state_nx = LOAD;
      LOAD: begin
        if (!ld_start) begin
          if (ld_valid) begin
            asm_nx = asm_ins;
            cnt_nx = cnt + 2'd1;
            commit = (cnt == 2'd3);
          end
          // A byte arriving with ld_done is folded into the flush; a word
          // completed on that same edge is still written only once.
          if (ld_done) begin
            state_nx = HOLD;
            if (cnt != 2'd0 || ld_valid) commit = 1'b1;
          end
          if (commit) begin
            cnt_nx = 2'd0;
            asm_nx = '0;
            if (ptr == PTR_FULL) begin
              ovf_nx = 1'b1;
            end else begin
              im_we  = 1'b1;
              ptr_nx = ptr + 1'b1;
            end
          end
        end
      end
      default: state_nx = HOLD;
    endcase

    if (ld_start && state != LOAD) state_nx = LOAD;
    if (ld_start) begin
      cnt_nx = 2'd0;
      ptr_nx = '0;
      asm_nx = '0;
      ovf_nx = 1'b0;
      im_we  = 1'b0;
    end
  end

  assign dm_we    = (state == RUN) && mem_write && (alu_result < DMEM_BYTES);
  assign io_we    = (state == RUN) && mem_write && (alu_result == IO_ADDR);
  assign ld_ready = (state == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      cpu_reset   <= 1'b1;
      cnt         <= '0;
      ptr         <= '0;
      asm_q       <= '0;
      ld_overflow <= 1'b0;
      io_out      <= '0;
    end else begin
      state       <= state_nx;
      cpu_reset   <= (state_nx != RUN);
      cnt         <= cnt_nx;
      ptr         <= ptr_nx;
      asm_q       <= asm_nx;
      ld_overflow <= ovf_nx;
      if (io_we) io_out <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (im_we) imem[ptr[IA-1:0]] <= word;
    if (dm_we) dmem[alu_result[DA+1:2]] <= write_data;
  end

  always_comb begin
    instr = '0;
    if (pc < IMEM_BYTES) instr = imem[pc[IA+1:2]];
  end

  always_comb begin
    read_data = '0;
    if (alu_result < DMEM_BYTES)   read_data = dmem[alu_result[DA+1:2]];
    else if (alu_result == IO_ADDR) read_data = io_out;
  end

endmodule
